pe_array_controller: RTL and testbench

Sequencer for a ROWS×COLS weight-stationary systolic array of Processing_Element instances. On each Start it clears the array, loads one weight row per cycle, then streams KLen input vectors and holds enable through fill/drain. It also flags, per output column, the cycles on which the bottom-row PsumOut is a finished result. It sits between the layer-level scheduler (Start/Done) and the PE array plus its weight/input buffers.

---
 rtl/pe_array_controller_if.sv | 32 +++
 rtl/pe_array_controller.sv | 86 ++++++++
 tb/tb_pe_array_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_controller_if.sv
// Scheduler/PE-array bundle for pe_array_controller: tile command inputs plus array sequencing outputs.
// The master side issues Start/Abort/KLen; the slave side is the controller.
interface pe_array_controller_if #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic               Start;
    logic               Abort;
    logic [K_WIDTH-1:0] KLen;
    logic               Busy;
    logic               Done;
    logic               PeSyncRst;
    logic               PeLoad;
    logic               PeEn;
    logic [RW-1:0]      WRowIdx;
    logic               InReq;
    logic [K_WIDTH-1:0] InIdx;
    logic [COLS-1:0]    OutColValid;

    modport master (
        output Start, Abort, KLen,
        input  Busy, Done, PeSyncRst, PeLoad, PeEn, WRowIdx, InReq, InIdx, OutColValid
    );

    modport slave (
        input  Start, Abort, KLen,
        output Busy, Done, PeSyncRst, PeLoad, PeEn, WRowIdx, InReq, InIdx, OutColValid
    );
endinterface

// File: rtl/pe_array_controller.sv
// Systolic-array tile sequencer: clear, load ROWS weight rows, stream KLen vectors, drain, pulse Done.
// Start->Done is 2*ROWS+COLS+KLen cycles (ROWS+2 for KLen=0); no backpressure, Abort returns to IDLE.
module pe_array_controller #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  ASYNC_RST,
    pe_array_controller_if.slave  bus
);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_LEN = ROWS + COLS - 2;
    // Wide enough that KLen+ROWS+COLS-2 never wraps.
    localparam int TW        = K_WIDTH + 1 + $clog2(ROWS + COLS + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      row_cnt;
    logic [TW-1:0]      t_cnt;
    logic [K_WIDTH-1:0] klen_q;
    logic [TW-1:0]      klen_t;
    logic               last_row, compute_end, drain_end;

    assign klen_t      = TW'(klen_q);
    assign last_row    = (row_cnt == RW'(ROWS - 1));
    assign compute_end = (t_cnt == klen_t - TW'(1));
    assign drain_end   = (t_cnt == klen_t + TW'(DRAIN_LEN) - TW'(1));

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state   <= IDLE;
            row_cnt <= '0;
            t_cnt   <= '0;
            klen_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.Start)
                klen_q <= bus.KLen;
            if (state == LOAD_W && state_nxt == LOAD_W)
                row_cnt <= row_cnt + RW'(1);
            else
                row_cnt <= '0;
            // Phase counter runs from the first COMPUTE cycle and carries into DONE.
            if ((state == COMPUTE || state == DRAIN) && state_nxt != IDLE)
                t_cnt <= t_cnt + TW'(1);
            else
                t_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD_W;
            LOAD_W:  if (last_row) state_nxt = (klen_q == '0) ? DONE : COMPUTE;
            COMPUTE: if (compute_end) state_nxt = (DRAIN_LEN == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.Abort && state != IDLE)
            state_nxt = IDLE;
    end

    // Moore outputs: decoded purely from the state and counter registers.
    always_comb begin
        bus.Busy        = (state != IDLE);
        bus.Done        = (state == DONE);
        bus.PeSyncRst   = (state == CLEAR);
        bus.PeLoad      = (state == LOAD_W);
        bus.WRowIdx     = (state == LOAD_W) ? row_cnt : '0;
        bus.PeEn        = (state == COMPUTE) || (state == DRAIN);
        bus.InReq       = (state == COMPUTE);
        bus.InIdx       = (state == COMPUTE) ? t_cnt[K_WIDTH-1:0] : '0;
        bus.OutColValid = '0;
        if (state == COMPUTE || state == DRAIN || state == DONE) begin
            for (int c = 0; c < COLS; c++) begin
                bus.OutColValid[c] = (t_cnt >= TW'(ROWS + c)) &&
                                     (t_cnt < TW'(ROWS + c) + klen_t);
            end
        end
    end
endmodule

// File: tb/tb_pe_array_controller.sv
// Directed bench for pe_array_controller: a 4x4 instance and a 1x1 instance with hand-derived schedules.
module tb_pe_array_controller;
    logic CLK = 1'b0;
    logic ASYNC_RST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    pe_array_controller_if #(.ROWS(4), .COLS(4), .K_WIDTH(16)) bus4 ();
    pe_array_controller_if #(.ROWS(1), .COLS(1), .K_WIDTH(16)) bus1 ();

    pe_array_controller #(.ROWS(4), .COLS(4), .K_WIDTH(16)) dut4 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .bus(bus4.slave));
    pe_array_controller #(.ROWS(1), .COLS(1), .K_WIDTH(16)) dut1 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .bus(bus1.slave));

    // {Busy,Done,PeSyncRst,PeLoad,PeEn,InReq,WRowIdx[1:0],InIdx[15:0],OutColValid[3:0]}
    function automatic logic [27:0] obs4();
        return {bus4.Busy, bus4.Done, bus4.PeSyncRst, bus4.PeLoad, bus4.PeEn, bus4.InReq,
                bus4.WRowIdx, bus4.InIdx, bus4.OutColValid};
    endfunction

    function automatic logic [23:0] obs1();
        return {bus1.Busy, bus1.Done, bus1.PeSyncRst, bus1.PeLoad, bus1.PeEn, bus1.InReq,
                bus1.WRowIdx, bus1.InIdx, bus1.OutColValid};
    endfunction

    // Expected 4x4 outputs in cycle cyc after Start was sampled at edge 0.
    function automatic logic [27:0] exp4(int cyc, int klen);
        int done_c;
        int t;
        logic [3:0]  ocv;
        logic [1:0]  row;
        logic [15:0] idx;
        logic busy, done, sync, load, en, inreq;
        done_c = (klen == 0) ? 6 : 12 + klen;
        t      = cyc - 6;
        busy   = (cyc >= 1) && (cyc <= done_c);
        done   = (cyc == done_c);
        sync   = (cyc == 1);
        load   = (cyc >= 2) && (cyc <= 5);
        row    = load ? 2'(cyc - 2) : 2'd0;
        en     = (klen > 0) && (cyc >= 6) && (cyc < done_c);
        inreq  = (cyc >= 6) && (cyc < 6 + klen);
        idx    = inreq ? 16'(cyc - 6) : 16'd0;
        for (int c = 0; c < 4; c++)
            ocv[c] = (cyc >= 6) && (cyc <= done_c) && (t >= 4 + c) && (t <= 3 + c + klen);
        return {busy, done, sync, load, en, inreq, row, idx, ocv};
    endfunction

    // Expected 1x1 outputs for KLen=2.
    function automatic logic [23:0] exp1(int cyc);
        logic busy, done, sync, load, en, inreq, ocv;
        logic [15:0] idx;
        busy  = (cyc >= 1) && (cyc <= 5);
        done  = (cyc == 5);
        sync  = (cyc == 1);
        load  = (cyc == 2);
        en    = (cyc == 3) || (cyc == 4);
        inreq = en;
        idx   = inreq ? 16'(cyc - 3) : 16'd0;
        ocv   = (cyc == 4) || (cyc == 5);
        return {busy, done, sync, load, en, inreq, 1'b0, idx, ocv};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ASYNC_RST = 1'b0;
        tick();
        tick();
        checks++;
        if (obs4() !== 28'd0) begin
            failures++;
            $display("FAIL reset_state4 got=%h want=%h", obs4(), 28'd0);
        end
        checks++;
        if (obs1() !== 24'd0) begin
            failures++;
            $display("FAIL reset_state1 got=%h want=%h", obs1(), 24'd0);
        end
        #2 ASYNC_RST = 1'b1;
        tick();
        checks++;
        if (obs4() !== 28'd0) begin
            failures++;
            $display("FAIL idle_after_release got=%h want=%h", obs4(), 28'd0);
        end
    endtask

    task automatic test_nominal();
        bus4.KLen  = 16'd3;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            checks++;
            if (obs4() !== exp4(cyc, 3)) begin
                failures++;
                $display("FAIL nominal_k3 cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 3));
            end
        end
    endtask

    task automatic test_small_array();
        bus1.KLen  = 16'd2;
        bus1.Start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            bus1.Start = 1'b0;
            checks++;
            if (obs1() !== exp1(cyc)) begin
                failures++;
                $display("FAIL small_1x1 cyc=%0d got=%h want=%h", cyc, obs1(), exp1(cyc));
            end
        end
    endtask

    task automatic test_klen_zero();
        bit en_seen = 1'b0;
        bus4.KLen  = 16'd0;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            if (bus4.PeEn) en_seen = 1'b1;
            checks++;
            if (obs4() !== exp4(cyc, 0)) begin
                failures++;
                $display("FAIL klen_zero cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 0));
            end
        end
        checks++;
        if (en_seen !== 1'b0) begin
            failures++;
            $display("FAIL klen_zero_pe_en got=%0b want=0", en_seen);
        end
    endtask

    task automatic test_abort();
        bit done_seen = 1'b0;
        bus4.KLen  = 16'd3;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            checks++;
            if (obs4() !== exp4(cyc, 3)) begin
                failures++;
                $display("FAIL abort_pre cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 3));
            end
        end
        bus4.Abort = 1'b1;
        tick();
        bus4.Abort = 1'b0;
        checks++;
        if (obs4() !== 28'd0) begin
            failures++;
            $display("FAIL abort_to_idle got=%h want=%h", obs4(), 28'd0);
        end
        for (int cyc = 9; cyc <= 20; cyc++) begin
            tick();
            if (bus4.Done || bus4.Busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%0b want=0", done_seen);
        end
        // Restart with Abort also high in IDLE: Start takes priority.
        bus4.KLen  = 16'd1;
        bus4.Start = 1'b1;
        bus4.Abort = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            bus4.Abort = 1'b0;
            checks++;
            if (obs4() !== exp4(cyc, 1)) begin
                failures++;
                $display("FAIL abort_restart cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 1));
            end
        end
    endtask

    task automatic test_busy_ignore();
        bus4.KLen  = 16'd3;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            checks++;
            if (obs4() !== exp4(cyc, 3)) begin
                failures++;
                $display("FAIL busy_ignore cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 3));
            end
            if (cyc == 3 || cyc == 10) begin
                bus4.Start = 1'b1;
                bus4.KLen  = 16'd7;
            end
        end
        bus4.KLen = 16'd3;
    endtask

    task automatic test_back_to_back();
        bus4.KLen  = 16'd1;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            checks++;
            if (obs4() !== exp4(cyc, 1)) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 1));
            end
        end
        tick();
        bus4.Start = 1'b0;
        checks++;
        if (obs4() !== exp4(1, 1)) begin
            failures++;
            $display("FAIL back_to_back_restart got=%h want=%h", obs4(), exp4(1, 1));
        end
        bus4.Abort = 1'b1;
        tick();
        bus4.Abort = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus4.KLen  = 16'd3;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            bus4.Start = 1'b0;
        end
        #2 ASYNC_RST = 1'b0;
        #1;
        checks++;
        if (obs4() !== 28'd0) begin
            failures++;
            $display("FAIL async_reset_mid_compute got=%h want=%h", obs4(), 28'd0);
        end
        tick();
        #2 ASYNC_RST = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs4() !== 28'd0) begin
            failures++;
            $display("FAIL async_reset_stays_idle got=%h want=%h", obs4(), 28'd0);
        end
        bus4.KLen  = 16'd2;
        bus4.Start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            bus4.Start = 1'b0;
            checks++;
            if (obs4() !== exp4(cyc, 2)) begin
                failures++;
                $display("FAIL restart_after_reset cyc=%0d got=%h want=%h", cyc, obs4(), exp4(cyc, 2));
            end
        end
    endtask

    initial begin
        bus4.Start = 1'b0;
        bus4.Abort = 1'b0;
        bus4.KLen  = 16'd0;
        bus1.Start = 1'b0;
        bus1.Abort = 1'b0;
        bus1.KLen  = 16'd0;
        test_reset();
        test_nominal();
        test_small_array();
        test_klen_zero();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
